// File: rtl/seq_detect_ctrl_pkg.sv
// seq_detect_ctrl shared types, default sizes and helpers.
// Imported by seq_match_shift and seq_detect_ctrl.
package seq_detect_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // Low 'len' bits set; callers truncate to their pattern width.
    function automatic logic [31:0] len_mask(input int unsigned len);
        if (len >= 32)
            return '1;
        else
            return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_match_shift.sv
// History shift register, fill counter and masked pattern compare.
// hit is combinational on the post-shift history of the current bit.
module seq_match_shift
    import seq_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             clr,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_nxt;

    // Post-shift view of history/fill and the masked compare.
    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], x};
        fill_nxt = (fill >= FULL) ? FULL : fill + 1'b1;
        mask     = PAT_W'(len_mask(32'(len)));
        hit      = x_valid && (fill_nxt >= len) &&
                   (((hist_nxt ^ pattern) & mask) == '0);
    end

    // History and fill update; non-overlap mode restarts the fill on a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (x_valid) begin
            hist <= hist_nxt;
            fill <= (hit && !overlap) ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detection controller (FSM, cfg, counter).
// Optional len range checking with err output: SEQ_DETECT_CTRL_ERR_EN.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
`ifdef SEQ_DETECT_CTRL_ERR_EN
    output logic             err,
`endif
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;

    logic [PAT_W-1:0] sh_pat;
    logic [LEN_W-1:0] sh_len;
    logic [CNT_W-1:0] sh_thr;
    logic             sh_ov;

    logic [PAT_W-1:0] act_pat;
    logic [LEN_W-1:0] act_len;
    logic [CNT_W-1:0] act_thr;
    logic             act_ov;

    logic [LEN_W-1:0] eff_len;
    logic [CNT_W-1:0] cnt_inc;
    logic             go;
    logic             feed;
    logic             hit;
    logic             cfg_ok;

`ifdef SEQ_DETECT_CTRL_ERR_EN
    logic             len_ok;
    logic             refuse;
    assign len_ok = (sh_len != '0) && (sh_len <= LEN_MAX);
`endif

    assign cfg_ok  = (state == IDLE) && cfg_we;
    assign feed    = (state == ARMED) && x_valid && !stop;
    assign cnt_inc = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
    assign busy    = (state == ARMED);
    assign done    = (state == DONE);

    // Out-of-range lengths are clamped into 1..PAT_W for the matcher.
    always_comb begin
        eff_len = act_len;
        if (act_len == '0)
            eff_len = LEN_ONE;
        else if (act_len > LEN_MAX)
            eff_len = LEN_MAX;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and start acceptance; stop has priority over start.
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
`ifdef SEQ_DETECT_CTRL_ERR_EN
        refuse    = 1'b0;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
`ifdef SEQ_DETECT_CTRL_ERR_EN
                    if (len_ok)
                        go = 1'b1;
                    else
                        refuse = 1'b1;
`else
                    go = 1'b1;
`endif
                end
                if (go)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (stop)
                    state_nxt = IDLE;
                else if (hit && (act_thr != '0) && (cnt_inc == act_thr))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow cfg written in IDLE; active cfg captured on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_pat  <= '0;
            sh_len  <= '0;
            sh_thr  <= '0;
            sh_ov   <= 1'b0;
            act_pat <= '0;
            act_len <= '0;
            act_thr <= '0;
            act_ov  <= 1'b0;
        end else begin
            if (cfg_ok) begin
                sh_pat <= cfg_pattern;
                sh_len <= cfg_len;
                sh_thr <= cfg_thresh;
                sh_ov  <= cfg_overlap;
            end
            if (go) begin
                act_pat <= sh_pat;
                act_len <= sh_len;
                act_thr <= sh_thr;
                act_ov  <= sh_ov;
            end
        end
    end

    // Registered match pulse and saturating match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= hit;
            if (go)
                match_cnt <= '0;
            else if (hit)
                match_cnt <= cnt_inc;
        end
    end

`ifdef SEQ_DETECT_CTRL_ERR_EN
    // Refused start raises err; accepted start or a cfg write clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (refuse)
            err <= 1'b1;
        else if (go || cfg_ok)
            err <= 1'b0;
    end
`endif

    seq_match_shift #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .x_valid (feed),
        .clr     (go),
        .len     (eff_len),
        .pattern (act_pat),
        .overlap (act_ov),
        .hit     (hit)
    );

endmodule
